// File: rtl/axi4_lite_read_slave_pkg.sv
// Shared types for the AXI4-lite read slave: FSM states and RRESP encodings.
// The DELAY state exists only when AXI_RD_DELAY_INJECT_EN is defined.
package axi4_lite_read_slave_pkg;

`ifdef AXI_RD_DELAY_INJECT_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RESP     = 2'd2,
    ST_DELAY    = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_e;
`endif

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } rresp_e;

  // Memory is doubleword addressed; low address bits must be zero.
  localparam int unsigned DW_ALIGN_BITS = 3;

endpackage

// File: rtl/axi4_lite_read_slave_if.sv
// AXI4-lite read channel plus simple memory request/ack port.
interface axi4_lite_read_slave_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_ACK;
  logic [DATA_W-1:0] MEM_DATA;

  modport slave (
    input  ARVALID, ARADDR, RREADY, MEM_ACK, MEM_DATA,
    output ARREADY, RVALID, RDATA, RRESP, MEM_REQ, MEM_ADDR
  );

  modport master (
    output ARVALID, ARADDR, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport mem (
    input  MEM_REQ, MEM_ADDR,
    output MEM_ACK, MEM_DATA
  );
endinterface

// File: rtl/axi4_lite_read_slave.sv
// AXI4-lite read slave with one outstanding read, memory wait timeout (DECERR)
// and misalignment error (SLVERR). Optional DELAY state: AXI_RD_DELAY_INJECT_EN.
module axi4_lite_read_slave
  import axi4_lite_read_slave_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 255
`ifdef AXI_RD_DELAY_INJECT_EN
  ,
  parameter int unsigned DELAY_CYC = 3
`endif
) (
  input logic                   CLK,
  input logic                   RST,
  axi4_lite_read_slave_if.slave bus
);

`ifdef AXI_RD_DELAY_INJECT_EN
  localparam int unsigned CNT_MAX = (TIMEOUT > DELAY_CYC) ? TIMEOUT : DELAY_CYC;
`else
  localparam int unsigned CNT_MAX = TIMEOUT;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  state_e            state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  rresp_e            rresp_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  cnt_q;

  assign bus.ARREADY  = arready_q;
  assign bus.RVALID   = rvalid_q;
  assign bus.RDATA    = rdata_q;
  assign bus.RRESP    = rresp_q;
  assign bus.MEM_REQ  = mem_req_q;
  assign bus.MEM_ADDR = mem_addr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (bus.ARVALID && arready_q) begin
            arready_q <= 1'b0;
            cnt_q     <= '0;
            if (bus.ARADDR[DW_ALIGN_BITS-1:0] != '0) begin
              state_q  <= ST_RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
            end else begin
              state_q    <= ST_MEM_WAIT;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {bus.ARADDR[ADDR_W-1:DW_ALIGN_BITS], {DW_ALIGN_BITS{1'b0}}};
            end
          end
        end

        ST_MEM_WAIT: begin
          // Ack is tested before the timeout so a last-cycle ack still returns OKAY.
          if (bus.MEM_ACK || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            mem_req_q <= 1'b0;
            rdata_q   <= bus.MEM_ACK ? bus.MEM_DATA : '0;
            rresp_q   <= bus.MEM_ACK ? RESP_OKAY : RESP_DECERR;
`ifdef AXI_RD_DELAY_INJECT_EN
            state_q   <= ST_DELAY;
            cnt_q     <= '0;
`else
            state_q   <= ST_RESP;
            rvalid_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef AXI_RD_DELAY_INJECT_EN
        ST_DELAY: begin
          if (cnt_q == CNT_W'(DELAY_CYC - 1)) begin
            state_q  <= ST_RESP;
            rvalid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        ST_RESP: begin
          if (bus.RREADY) begin
            state_q   <= ST_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Directed bench for axi4_lite_read_slave (default build, TIMEOUT=8).
module tb_axi4_lite_read_slave;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic CLK;
  logic RST;
  int   n_total = 0;
  int   n_bad   = 0;

  axi4_lite_read_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  axi4_lite_read_slave #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus_if.ARVALID  = 1'b0;
    bus_if.ARADDR   = '0;
    bus_if.RREADY   = 1'b0;
    bus_if.MEM_ACK  = 1'b0;
    bus_if.MEM_DATA = '0;
    RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    check("rst_arready", 64'(bus_if.ARREADY), 64'd0);
    check("rst_rvalid",  64'(bus_if.RVALID),  64'd0);
    check("rst_memreq",  64'(bus_if.MEM_REQ), 64'd0);
    check("rst_rdata",   bus_if.RDATA,        64'd0);
    check("rst_rresp",   64'(bus_if.RRESP),   64'd0);
    check("rst_memaddr", bus_if.MEM_ADDR,     64'd0);
    tick(); tick();
    RST = 1'b1;
    tick();
    check("arready_after_rst", 64'(bus_if.ARREADY), 64'd1);

    // stray MEM_ACK in IDLE
    bus_if.MEM_ACK = 1'b1; bus_if.MEM_DATA = 64'h5555_5555_5555_5555;
    tick();
    bus_if.MEM_ACK = 1'b0;
    check("stray_ack_rvalid", 64'(bus_if.RVALID), 64'd0);
    check("stray_ack_rdata",  bus_if.RDATA,       64'd0);

    // aligned read, ack 3 cycles into the wait
    bus_if.ARVALID = 1'b1; bus_if.ARADDR = 64'h8000_0008; bus_if.RREADY = 1'b1;
    tick();
    bus_if.ARVALID = 1'b0;
    check("rd1_memreq",  64'(bus_if.MEM_REQ), 64'd1);
    check("rd1_memaddr", bus_if.MEM_ADDR,     64'h8000_0008);
    check("rd1_arready", 64'(bus_if.ARREADY), 64'd0);
    tick(); tick(); tick();
    check("rd1_wait_rvalid", 64'(bus_if.RVALID),  64'd0);
    check("rd1_wait_memreq", 64'(bus_if.MEM_REQ), 64'd1);
    bus_if.MEM_ACK = 1'b1; bus_if.MEM_DATA = 64'hDEAD_BEEF_0011_2233;
    tick();
    bus_if.MEM_ACK = 1'b0;
    check("rd1_rvalid", 64'(bus_if.RVALID),  64'd1);
    check("rd1_rdata",  bus_if.RDATA,        64'hDEAD_BEEF_0011_2233);
    check("rd1_rresp",  64'(bus_if.RRESP),   64'd0);
    check("rd1_memreq_drop", 64'(bus_if.MEM_REQ), 64'd0);
    tick();
    check("rd1_done_rvalid",  64'(bus_if.RVALID),  64'd0);
    check("rd1_done_arready", 64'(bus_if.ARREADY), 64'd1);

    // misaligned read -> SLVERR, no memory access
    bus_if.ARVALID = 1'b1; bus_if.ARADDR = 64'h8000_0004; bus_if.RREADY = 1'b0;
    tick();
    bus_if.ARVALID = 1'b0;
    check("mis_rvalid", 64'(bus_if.RVALID),  64'd1);
    check("mis_memreq", 64'(bus_if.MEM_REQ), 64'd0);
    check("mis_rresp",  64'(bus_if.RRESP),   64'd2);
    check("mis_rdata",  bus_if.RDATA,        64'd0);
    bus_if.RREADY = 1'b1;
    tick();
    check("mis_done_rvalid", 64'(bus_if.RVALID), 64'd0);

    // timeout -> DECERR after 8 wait cycles, then stalled response
    bus_if.ARVALID = 1'b1; bus_if.ARADDR = 64'h10; bus_if.RREADY = 1'b0;
    tick();
    bus_if.ARVALID = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && bus_if.MEM_REQ; i++) begin
      n++;
      tick();
    end
    check("to_wait_cycles", 64'(n), 64'd8);
    check("to_rvalid", 64'(bus_if.RVALID), 64'd1);
    check("to_rresp",  64'(bus_if.RRESP),  64'd3);
    check("to_rdata",  bus_if.RDATA,       64'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bus_if.ARVALID = 1'b1; bus_if.ARADDR = 64'h0; end
      if (i == 3) bus_if.ARVALID = 1'b0;
      tick();
      check("stall_rvalid",  64'(bus_if.RVALID),  64'd1);
      check("stall_rresp",   64'(bus_if.RRESP),   64'd3);
      check("stall_arready", 64'(bus_if.ARREADY), 64'd0);
    end
    bus_if.RREADY = 1'b1;
    tick();
    check("stall_done_rvalid", 64'(bus_if.RVALID),  64'd0);
    check("stall_done_memreq", 64'(bus_if.MEM_REQ), 64'd0);

    // ack on the final wait cycle wins over timeout
    bus_if.ARVALID = 1'b1; bus_if.ARADDR = 64'h20;
    tick();
    bus_if.ARVALID = 1'b0;
    repeat (7) tick();
    check("edge_memreq", 64'(bus_if.MEM_REQ), 64'd1);
    bus_if.MEM_ACK = 1'b1; bus_if.MEM_DATA = 64'h0123_4567_89AB_CDEF;
    tick();
    bus_if.MEM_ACK = 1'b0;
    check("edge_rvalid", 64'(bus_if.RVALID), 64'd1);
    check("edge_rresp",  64'(bus_if.RRESP),  64'd0);
    check("edge_rdata",  bus_if.RDATA,       64'h0123_4567_89AB_CDEF);
    tick();

    // reset during MEM_WAIT
    bus_if.ARVALID = 1'b1; bus_if.ARADDR = 64'h40;
    tick();
    bus_if.ARVALID = 1'b0;
    check("mr_memreq", 64'(bus_if.MEM_REQ), 64'd1);
    #1 RST = 1'b0;
    #1;
    check("mr_memreq_rst",  64'(bus_if.MEM_REQ), 64'd0);
    check("mr_memaddr_rst", bus_if.MEM_ADDR,     64'd0);
    check("mr_rdata_rst",   bus_if.RDATA,        64'd0);
    check("mr_arready_rst", 64'(bus_if.ARREADY), 64'd0);
    tick();
    RST = 1'b1;
    tick();
    check("mr_arready_rel", 64'(bus_if.ARREADY), 64'd1);
    check("mr_rvalid_rel",  64'(bus_if.RVALID),  64'd0);
    tick();
    check("mr_rvalid_later", 64'(bus_if.RVALID), 64'd0);

    // back-to-back reads
    bus_if.RREADY = 1'b1; bus_if.ARVALID = 1'b1; bus_if.ARADDR = 64'h0;
    tick();
    bus_if.ARADDR = 64'h8;
    check("b2b_a_memaddr", bus_if.MEM_ADDR, 64'h0);
    bus_if.MEM_ACK = 1'b1; bus_if.MEM_DATA = 64'hAAAA_0000_1111_2222;
    tick();
    bus_if.MEM_ACK = 1'b0;
    check("b2b_a_rvalid", 64'(bus_if.RVALID), 64'd1);
    check("b2b_a_rdata",  bus_if.RDATA,       64'hAAAA_0000_1111_2222);
    tick();
    check("b2b_idle_arready", 64'(bus_if.ARREADY), 64'd1);
    tick();
    bus_if.ARVALID = 1'b0;
    check("b2b_b_memreq",  64'(bus_if.MEM_REQ), 64'd1);
    check("b2b_b_memaddr", bus_if.MEM_ADDR,     64'h8);
    bus_if.MEM_ACK = 1'b1; bus_if.MEM_DATA = 64'hBBBB_3333_4444_5555;
    tick();
    bus_if.MEM_ACK = 1'b0;
    check("b2b_b_rvalid", 64'(bus_if.RVALID), 64'd1);
    check("b2b_b_rdata",  bus_if.RDATA,       64'hBBBB_3333_4444_5555);
    tick();
    check("b2b_done_rvalid", 64'(bus_if.RVALID), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
